writeback_register_arbiter: RTL and testbench

- Write-side producer for the two-read-port general register file.
- Accepts results from the ALU and load/store execution paths and buffers each stream in its own FIFO.
- Arbitrates between the two streams and issues at most one register-file write per cycle on a registered write port.
- Provides a pending-write probe so allocate/issue logic can detect outstanding writes to a register.

---
 rtl/writeback_pkg.sv | 20 ++
 rtl/writeback_fifo.sv | 93 +++++++++
 rtl/writeback_register_arbiter.sv | 160 ++++++++++++++++
 tb/tb_writeback_register_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared types and constants for the register-file writeback path.
// Optional build macro MIST32_WB_LDST_PRIORITY_EN is consumed by
// writeback_register_arbiter (fixed LDST priority instead of round-robin).
package writeback_pkg;

   localparam int WB_ADDR_W          = 5;
   localparam int WB_DATA_W          = 32;
   localparam int WB_DEFAULT_DEPTH   = 4;
   localparam int WB_DEFAULT_DEPTH_N = 2;

   // Source identifiers, also used as the round-robin pointer encoding
   localparam logic WB_SRC_ALU  = 1'b0;
   localparam logic WB_SRC_LDST = 1'b1;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_fifo.sv
// Single-clock FIFO of pending register writes for one result source.
// The head entry is readable combinationally so it can be popped and
// loaded into the output stage on the same edge. Every slot's valid bit
// and destination address are exported for the pending-write probe.
module writeback_fifo
   import writeback_pkg::*;
#(
   parameter int P_DEPTH   = WB_DEFAULT_DEPTH,
   parameter int P_DEPTH_N = WB_DEFAULT_DEPTH_N
) (
   input  logic                           iCLOCK,
   input  logic                           iRESET_SYNC,
   input  logic                           push,
   input  wb_entry_t                      push_entry,
   input  logic                           pop,
   output wb_entry_t                      head_entry,
   output logic                           empty,
   output logic                           full,
   output logic [P_DEPTH-1:0]             entry_valid,
   output logic [P_DEPTH*WB_ADDR_W-1:0]   entry_addr
);

   localparam logic [P_DEPTH_N:0] DEPTH_C = (P_DEPTH_N+1)'(P_DEPTH);

   wb_entry_t              mem [P_DEPTH];
   logic [P_DEPTH_N-1:0]   wr_ptr_reg;
   logic [P_DEPTH_N-1:0]   rd_ptr_reg;
   logic [P_DEPTH_N:0]     count_reg;
   logic [P_DEPTH_N:0]     count_next;
   logic                   full_reg;
   logic [P_DEPTH-1:0]     valid_reg;
   logic                   push_ok;
   logic                   pop_ok;

   // A push into a full FIFO is dropped; a pop of an empty FIFO is ignored
   assign push_ok = push && !full_reg;
   assign pop_ok  = pop && (count_reg != '0);

   // Next occupancy; simultaneous push and pop leave it unchanged
   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Pointers wrap naturally because the depth is a power of two
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         full_reg  <= (count_next == DEPTH_C);
      end
   end

   // Payload storage; contents of empty slots are don't-care
   always_ff @(posedge iCLOCK) begin
      if (push_ok && !iRESET_SYNC)
         mem[wr_ptr_reg] <= push_entry;
   end

   // Per-slot occupancy. Push and pop never hit the same slot in one
   // cycle: that would need the FIFO to be both empty and non-empty.
   generate
      for (genvar gi = 0; gi < P_DEPTH; gi++) begin : g_slot
         always_ff @(posedge iCLOCK) begin
            if (iRESET_SYNC)
               valid_reg[gi] <= 1'b0;
            else if (push_ok && (wr_ptr_reg == P_DEPTH_N'(gi)))
               valid_reg[gi] <= 1'b1;
            else if (pop_ok && (rd_ptr_reg == P_DEPTH_N'(gi)))
               valid_reg[gi] <= 1'b0;
         end
         assign entry_addr[gi*WB_ADDR_W +: WB_ADDR_W] = mem[gi].addr;
      end
   endgenerate

   assign entry_valid = valid_reg;
   assign head_entry  = mem[rd_ptr_reg];
   assign empty       = (count_reg == '0);
   assign full        = full_reg;

endmodule

// File: rtl/writeback_register_arbiter.sv
// Register-file write producer: buffers ALU and LDST results in separate
// FIFOs, picks at most one per cycle and drives a registered write port.
// Build macro MIST32_WB_LDST_PRIORITY_EN: when defined, LDST always wins
// contention and no round-robin pointer exists; otherwise round-robin.
module writeback_register_arbiter
   import writeback_pkg::*;
#(
   parameter int P_DEPTH   = WB_DEFAULT_DEPTH,
   parameter int P_DEPTH_N = WB_DEFAULT_DEPTH_N
) (
   input  logic                  iCLOCK,
   input  logic                  iRESET_SYNC,
   input  logic                  iALU_VALID,
   input  logic [WB_ADDR_W-1:0]  iALU_ADDR,
   input  logic [WB_DATA_W-1:0]  iALU_DATA,
   output logic                  oALU_LOCK,
   input  logic                  iLDST_VALID,
   input  logic [WB_ADDR_W-1:0]  iLDST_ADDR,
   input  logic [WB_DATA_W-1:0]  iLDST_DATA,
   output logic                  oLDST_LOCK,
   input  logic [WB_ADDR_W-1:0]  iCHK_ADDR,
   output logic                  oCHK_PENDING,
   output logic                  oWR_VALID,
   output logic [WB_ADDR_W-1:0]  oWR_ADDR,
   output logic [WB_DATA_W-1:0]  oWR_DATA
);

   wb_entry_t                    alu_push_entry;
   wb_entry_t                    ldst_push_entry;
   wb_entry_t                    alu_head;
   wb_entry_t                    ldst_head;
   logic                         alu_empty;
   logic                         ldst_empty;
   logic                         alu_full;
   logic                         ldst_full;
   logic [P_DEPTH-1:0]           alu_entry_valid;
   logic [P_DEPTH-1:0]           ldst_entry_valid;
   logic [P_DEPTH*WB_ADDR_W-1:0] alu_entry_addr;
   logic [P_DEPTH*WB_ADDR_W-1:0] ldst_entry_addr;
   logic [P_DEPTH-1:0]           alu_hit;
   logic [P_DEPTH-1:0]           ldst_hit;
   logic                         grant_alu;
   logic                         grant_ldst;
   logic                         wr_valid_reg;
   logic [WB_ADDR_W-1:0]         wr_addr_reg;
   logic [WB_DATA_W-1:0]         wr_data_reg;
`ifndef MIST32_WB_LDST_PRIORITY_EN
   logic                         rr_ptr_reg;
   logic                         rr_ptr_next;
`endif

   assign alu_push_entry  = '{addr: iALU_ADDR,  data: iALU_DATA};
   assign ldst_push_entry = '{addr: iLDST_ADDR, data: iLDST_DATA};

   writeback_fifo #(.P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N)) u_alu_fifo (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .push        (iALU_VALID),
      .push_entry  (alu_push_entry),
      .pop         (grant_alu),
      .head_entry  (alu_head),
      .empty       (alu_empty),
      .full        (alu_full),
      .entry_valid (alu_entry_valid),
      .entry_addr  (alu_entry_addr)
   );

   writeback_fifo #(.P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N)) u_ldst_fifo (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .push        (iLDST_VALID),
      .push_entry  (ldst_push_entry),
      .pop         (grant_ldst),
      .head_entry  (ldst_head),
      .empty       (ldst_empty),
      .full        (ldst_full),
      .entry_valid (ldst_entry_valid),
      .entry_addr  (ldst_entry_addr)
   );

   assign oALU_LOCK  = alu_full;
   assign oLDST_LOCK = ldst_full;

`ifdef MIST32_WB_LDST_PRIORITY_EN
   // Fixed priority: LDST wins whenever it has an entry
   always_comb begin
      grant_alu  = 1'b0;
      grant_ldst = 1'b0;
      if (!ldst_empty)
         grant_ldst = 1'b1;
      else if (!alu_empty)
         grant_alu = 1'b1;
   end
`else
   // Round-robin: the pointer decides contention and only moves then
   always_comb begin
      grant_alu   = 1'b0;
      grant_ldst  = 1'b0;
      rr_ptr_next = rr_ptr_reg;
      if (!alu_empty && !ldst_empty) begin
         if (rr_ptr_reg == WB_SRC_ALU) begin
            grant_alu   = 1'b1;
            rr_ptr_next = WB_SRC_LDST;
         end else begin
            grant_ldst  = 1'b1;
            rr_ptr_next = WB_SRC_ALU;
         end
      end else if (!alu_empty) begin
         grant_alu = 1'b1;
      end else if (!ldst_empty) begin
         grant_ldst = 1'b1;
      end
   end

   // Round-robin pointer state
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC)
         rr_ptr_reg <= WB_SRC_ALU;
      else
         rr_ptr_reg <= rr_ptr_next;
   end
`endif

   // Output stage: load the granted head; address/data hold when idle
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wr_valid_reg <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
      end else if (grant_alu) begin
         wr_valid_reg <= 1'b1;
         wr_addr_reg  <= alu_head.addr;
         wr_data_reg  <= alu_head.data;
      end else if (grant_ldst) begin
         wr_valid_reg <= 1'b1;
         wr_addr_reg  <= ldst_head.addr;
         wr_data_reg  <= ldst_head.data;
      end else begin
         wr_valid_reg <= 1'b0;
      end
   end

   assign oWR_VALID = wr_valid_reg;
   assign oWR_ADDR  = wr_addr_reg;
   assign oWR_DATA  = wr_data_reg;

   // Pending probe: any queued slot or the output stage targeting iCHK_ADDR
   generate
      for (genvar gi = 0; gi < P_DEPTH; gi++) begin : g_probe
         assign alu_hit[gi]  = alu_entry_valid[gi] &&
                               (alu_entry_addr[gi*WB_ADDR_W +: WB_ADDR_W] == iCHK_ADDR);
         assign ldst_hit[gi] = ldst_entry_valid[gi] &&
                               (ldst_entry_addr[gi*WB_ADDR_W +: WB_ADDR_W] == iCHK_ADDR);
      end
   endgenerate

   assign oCHK_PENDING = (|alu_hit) || (|ldst_hit) ||
                         (wr_valid_reg && (wr_addr_reg == iCHK_ADDR));

endmodule

// File: tb/tb_writeback_register_arbiter.sv
// Directed bench for writeback_register_arbiter: inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_writeback_register_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_v;
   logic [4:0]  alu_a;
   logic [31:0] alu_d;
   logic        alu_lock;
   logic        ldst_v;
   logic [4:0]  ldst_a;
   logic [31:0] ldst_d;
   logic        ldst_lock;
   logic [4:0]  chk_a;
   logic        chk_p;
   logic        wr_v;
   logic [4:0]  wr_a;
   logic [31:0] wr_d;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   writeback_register_arbiter dut (
      .iCLOCK       (clk),
      .iRESET_SYNC  (rst),
      .iALU_VALID   (alu_v),
      .iALU_ADDR    (alu_a),
      .iALU_DATA    (alu_d),
      .oALU_LOCK    (alu_lock),
      .iLDST_VALID  (ldst_v),
      .iLDST_ADDR   (ldst_a),
      .iLDST_DATA   (ldst_d),
      .oLDST_LOCK   (ldst_lock),
      .iCHK_ADDR    (chk_a),
      .oCHK_PENDING (chk_p),
      .oWR_VALID    (wr_v),
      .oWR_ADDR     (wr_a),
      .oWR_DATA     (wr_d)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      alu_v  = av;
      alu_a  = aa;
      alu_d  = ad;
      ldst_v = lv;
      ldst_a = la;
      ldst_d = ld;
   endtask

   task automatic do_reset();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int alu_seen;
      int ldst_seen;
      int ldst_j;
      rst   = 1'b1;
      chk_a = 5'd0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      tick();
      check("rst_wr_valid", 32'(wr_v), 32'd0);
      check("rst_wr_addr", 32'(wr_a), 32'd0);
      check("rst_wr_data", wr_d, 32'd0);
      check("rst_alu_lock", 32'(alu_lock), 32'd0);
      check("rst_ldst_lock", 32'(ldst_lock), 32'd0);
      check("rst_pending", 32'(chk_p), 32'd0);
      rst = 1'b0;
      $display("reset state checked");

      // Single ALU write: pushed at E1, on the port after E2
      drive(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("single_e1_valid", 32'(wr_v), 32'd0);
      tick();
      check("single_valid", 32'(wr_v), 32'd1);
      check("single_addr", 32'(wr_a), 32'd3);
      check("single_data", wr_d, 32'h1234_5678);
      tick();
      check("single_idle_valid", 32'(wr_v), 32'd0);
      check("single_hold_addr", 32'(wr_a), 32'd3);
      check("single_hold_data", wr_d, 32'h1234_5678);
      $display("single ALU write r3 checked");

      // Contention, two rounds
      do_reset();
      drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      check("cont1_first_valid", 32'(wr_v), 32'd1);
`ifdef MIST32_WB_LDST_PRIORITY_EN
      check("cont1_first_addr", 32'(wr_a), 32'd2);
      check("cont1_first_data", wr_d, 32'hB);
      tick();
      check("cont1_second_addr", 32'(wr_a), 32'd1);
      check("cont1_second_data", wr_d, 32'hA);
`else
      check("cont1_first_addr", 32'(wr_a), 32'd1);
      check("cont1_first_data", wr_d, 32'hA);
      tick();
      check("cont1_second_addr", 32'(wr_a), 32'd2);
      check("cont1_second_data", wr_d, 32'hB);
`endif
      check("cont1_second_valid", 32'(wr_v), 32'd1);
      tick();
      check("cont1_idle", 32'(wr_v), 32'd0);
      drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      check("cont2_first_addr", 32'(wr_a), 32'd2);
      check("cont2_first_data", wr_d, 32'hB);
      tick();
      check("cont2_second_addr", 32'(wr_a), 32'd1);
      check("cont2_second_data", wr_d, 32'hA);
      tick();
      check("cont2_idle", 32'(wr_v), 32'd0);
      $display("contention rounds checked");

      // Full / lock
      do_reset();
`ifndef MIST32_WB_LDST_PRIORITY_EN
      alu_seen  = 0;
      ldst_seen = 0;
      ldst_j    = 0;
      for (int n = 1; n <= 17; n++) begin
         drive(n <= 8, 5'd1, 32'hA00 + 32'(n - 1),
               (n <= 6) || (n == 8), 5'd2, 32'hB00 + 32'(ldst_j));
         if ((n <= 6) || (n == 8))
            ldst_j++;
         tick();
         if (wr_v) begin
            if (wr_a == 5'd1) begin
               check("lock_alu_order", wr_d, 32'hA00 + 32'(alu_seen));
               alu_seen++;
            end else begin
               check("lock_ldst_order", wr_d, 32'hB00 + 32'(ldst_seen));
               ldst_seen++;
            end
         end
         if (n == 6) begin
            check("lock_e6_alu", 32'(alu_lock), 32'd0);
            check("lock_e6_ldst", 32'(ldst_lock), 32'd1);
         end
         if (n == 7) begin
            check("lock_e7_alu", 32'(alu_lock), 32'd1);
            check("lock_e7_ldst", 32'(ldst_lock), 32'd0);
         end
         if (n == 8) begin
            check("lock_e8_alu", 32'(alu_lock), 32'd0);
            check("lock_e8_ldst", 32'(ldst_lock), 32'd1);
         end
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("lock_alu_writes", 32'(alu_seen), 32'd7);
      check("lock_ldst_writes", 32'(ldst_seen), 32'd7);
`else
      for (int n = 1; n <= 4; n++) begin
         drive(1'b1, 5'd1, 32'hA00 + 32'(n), 1'b1, 5'd2, 32'hB00 + 32'(n));
         tick();
         check("prio_ldst_wins", 32'(wr_v && (wr_a == 5'd1)), 32'd0);
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("prio_alu_lock", 32'(alu_lock), 32'd1);
`endif
      $display("full/lock scenario checked");

      // Wrap-around: 10 back-to-back ALU pushes
      do_reset();
      for (int i = 0; i <= 11; i++) begin
         drive(i < 10, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0);
         tick();
         check("wrap_lock", 32'(alu_lock), 32'd0);
         if (i >= 1 && i <= 10) begin
            check("wrap_valid", 32'(wr_v), 32'd1);
            check("wrap_addr", 32'(wr_a), 32'(i - 1));
            check("wrap_data", wr_d, 32'(i - 1));
         end else begin
            check("wrap_idle", 32'(wr_v), 32'd0);
         end
      end
      $display("wrap-around r0..r9 checked");

      // Pending probe
      do_reset();
      chk_a = 5'd7;
      #1;
      check("pend_before", 32'(chk_p), 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("pend_queued", 32'(chk_p), 32'd1);
      chk_a = 5'd8;
      #1;
      check("pend_queued_r8", 32'(chk_p), 32'd0);
      chk_a = 5'd7;
      tick();
      check("pend_out_valid", 32'(wr_v), 32'd1);
      check("pend_out_stage", 32'(chk_p), 32'd1);
      chk_a = 5'd8;
      #1;
      check("pend_out_r8", 32'(chk_p), 32'd0);
      chk_a = 5'd7;
      tick();
      check("pend_after", 32'(chk_p), 32'd0);
      $display("pending probe r7/r8 checked");

      // Reset mid-operation
      do_reset();
      drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);
      tick();
      drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("mid_rst_valid", 32'(wr_v), 32'd0);
      check("mid_rst_alu_lock", 32'(alu_lock), 32'd0);
      check("mid_rst_ldst_lock", 32'(ldst_lock), 32'd0);
      chk_a = 5'd5;
      #1;
      check("mid_rst_pend_r5", 32'(chk_p), 32'd0);
      chk_a = 5'd6;
      #1;
      check("mid_rst_pend_r6", 32'(chk_p), 32'd0);
      chk_a = 5'd9;
      #1;
      check("mid_rst_pend_r9", 32'(chk_p), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_rst_no_write", 32'(wr_v), 32'd0);
      end
      $display("reset mid-operation checked");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
